// File: rtl/doe_core_arb_if.sv
// Requester/core bus for doe_core_arb.
//   slave  : arbiter view (requester commands and core status in; grants,
//            responses and core strobes out)
//   master : requester/core side view of the same signals
// Requester r uses bit r of each per-requester vector and slice
// [r*128 +: 128] of the block and IV buses.
interface doe_core_arb_if #(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned DW = 128;

  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    lock_i;
  logic [NUM_REQ-1:0]    cmd_init_i;
  logic [NUM_REQ-1:0]    cmd_next_i;
  logic [NUM_REQ*DW-1:0] cmd_block_i;
  logic [NUM_REQ*DW-1:0] cmd_iv_i;
  logic [NUM_REQ-1:0]    cmd_iv_upd_i;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic                  rsp_err_o;
  logic [DW-1:0]         rsp_data_o;
  logic                  cmd_err_o;
  logic                  busy_o;
  logic                  core_init;
  logic                  core_next;
  logic [DW-1:0]         core_block;
  logic [DW-1:0]         core_iv;
  logic                  core_iv_updated;
  logic                  core_ready;
  logic                  core_valid;
  logic [DW-1:0]         core_result;

  modport slave (
    input  req_i, lock_i, cmd_init_i, cmd_next_i, cmd_block_i, cmd_iv_i,
           cmd_iv_upd_i, core_ready, core_valid, core_result,
    output gnt_o, rsp_valid_o, rsp_err_o, rsp_data_o, cmd_err_o, busy_o,
           core_init, core_next, core_block, core_iv, core_iv_updated
  );

  modport master (
    output req_i, lock_i, cmd_init_i, cmd_next_i, cmd_block_i, cmd_iv_i,
           cmd_iv_upd_i, core_ready, core_valid, core_result,
    input  gnt_o, rsp_valid_o, rsp_err_o, rsp_data_o, cmd_err_o, busy_o,
           core_init, core_next, core_block, core_iv, core_iv_updated
  );
endinterface

// File: rtl/doe_core_arb.sv
// Round-robin arbiter/sequencer sharing one doe_core_cbc between NUM_REQ
// requesters. Grants the core, forwards init/next as one-cycle strobes,
// muxes block/IV from the owner and returns completion to the owner only.
//   clk, rst  : clock, synchronous active-high reset
//   zeroize   : synchronous abort/clear, same priority as rst
//   bus       : doe_core_arb_if.slave (requester and core handshakes)
// Optional feature: define DOE_ARB_WDT_EN to compile in a WAIT watchdog
// that answers with rsp_err_o=1 after TIMEOUT_CYCLES; otherwise WAIT has
// no time limit and rsp_err_o is tied low.
module doe_core_arb #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           zeroize,
  doe_core_arb_if.slave  bus
);
  localparam int unsigned DW = 128;
  localparam int unsigned IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    WAIT    = 2'd2
  } state_e;

  state_e             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]      rsp_data_q;
  logic               cmd_err_q;
  logic               core_init_q;
  logic               core_next_q;
  logic               is_next;
  logic               seen_busy;
`ifdef DOE_ARB_WDT_EN
  logic               rsp_err_q;
  logic [31:0]        wdt_cnt;
`endif

  logic               own_init;
  logic               own_next;
  logic               own_legal;
  logic               cmd_illegal;
  logic               wait_done;
  logic [IW-1:0]      owner_inc;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [IW:0]        cand;

  // Command legality: only the owner may strobe, only in GRANTED, one at a time.
  always_comb begin
    own_init    = bus.cmd_init_i[owner];
    own_next    = bus.cmd_next_i[owner];
    own_legal   = (state == GRANTED) && (own_init ^ own_next);
    cmd_illegal = |(bus.cmd_init_i & bus.cmd_next_i);
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if ((bus.cmd_init_i[r] || bus.cmd_next_i[r]) &&
          ((state != GRANTED) || (IW'(r) != owner))) begin
        cmd_illegal = 1'b1;
      end
    end
    wait_done = is_next ? bus.core_valid : (bus.core_ready && seen_busy);
    owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
  end

  // First requesting index at or after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!pick_vld && bus.req_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  // Arbitration / sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      cmd_err_q   <= 1'b0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      is_next     <= 1'b0;
      seen_busy   <= 1'b0;
`ifdef DOE_ARB_WDT_EN
      rsp_err_q   <= 1'b0;
      wdt_cnt     <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      cmd_err_q   <= cmd_illegal;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
`ifdef DOE_ARB_WDT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.core_ready && pick_vld) begin
            gnt_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner <= pick_idx;
            state <= GRANTED;
          end
        end
        GRANTED: begin
          if (own_legal) begin
            core_init_q <= own_init;
            core_next_q <= own_next;
            is_next     <= own_next;
            seen_busy   <= 1'b0;
`ifdef DOE_ARB_WDT_EN
            wdt_cnt     <= '0;
`endif
            state       <= WAIT;
          end else if (!bus.req_i[owner] && !bus.lock_i[owner] &&
                       !own_init && !own_next) begin
            gnt_q <= '0;
            ptr   <= owner_inc;
            state <= IDLE;
          end
        end
        WAIT: begin
`ifdef DOE_ARB_WDT_EN
          wdt_cnt <= wdt_cnt + 32'd1;
`endif
          // Init completes on the core's ready edge after it has gone busy.
          if (!is_next && !bus.core_ready) begin
            seen_busy <= 1'b1;
          end
          if (wait_done) begin
            rsp_valid_q <= gnt_q;
            if (is_next) begin
              rsp_data_q <= bus.core_result;
            end
            if (bus.lock_i[owner]) begin
              state <= GRANTED;
            end else begin
              gnt_q <= '0;
              ptr   <= owner_inc;
              state <= IDLE;
            end
          end
`ifdef DOE_ARB_WDT_EN
          // Timeout drops the grant regardless of lock.
          else if (wdt_cnt >= 32'(TIMEOUT_CYCLES)) begin
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= 1'b1;
            gnt_q       <= '0;
            ptr         <= owner_inc;
            state       <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block/IV mux from the current owner; zero with no grant.
  always_comb begin
    bus.core_block      = '0;
    bus.core_iv         = '0;
    bus.core_iv_updated = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (gnt_q[r]) begin
        bus.core_block      = bus.core_block | bus.cmd_block_i[r*DW +: DW];
        bus.core_iv         = bus.core_iv    | bus.cmd_iv_i[r*DW +: DW];
        bus.core_iv_updated = bus.core_iv_updated | bus.cmd_iv_upd_i[r];
      end
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.cmd_err_o   = cmd_err_q;
  assign bus.busy_o      = (state != IDLE);
  assign bus.core_init   = core_init_q;
  assign bus.core_next   = core_next_q;

`ifdef DOE_ARB_WDT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  logic unused_cfg;
  assign unused_cfg      = ^32'(TIMEOUT_CYCLES);
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_doe_core_arb.sv
// Self-checking bench for doe_core_arb (NUM_REQ=2, TIMEOUT_CYCLES=16).
// Expected values come from a transaction-level model: an integer
// round-robin pointer, a modulo search for the winner and the last
// returned result.
module tb_doe_core_arb;
  localparam int unsigned N   = 2;
  localparam int unsigned DW  = 128;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic zeroize;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int            ptr_m  = 0;
  logic [DW-1:0] data_m = '0;

  doe_core_arb_if #(.NUM_REQ(N)) bus ();

  doe_core_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .zeroize (zeroize),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int winner(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++) begin
      if (req[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v = '0;
    if (r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  // Present a request mask to an idle arbiter; grant must appear next cycle.
  task automatic request(input logic [N-1:0] req, output int w);
    bus.req_i = req;
    tick();
    w = winner(req, ptr_m);
    chk("grant", DW'(bus.gnt_o), DW'(onehot(w)));
    chk("busy_granted", DW'(bus.busy_o), DW'(w >= 0));
  endtask

  // Owner r issues one command and the core answers after lat cycles.
  task automatic run_cmd(input int r, input bit nxt, input int lat, input bit lock,
                         input logic [DW-1:0] res);
    logic [DW-1:0] blk;
    logic [DW-1:0] iv;
    blk = rnd128();
    iv  = rnd128();
    bus.cmd_block_i[r*DW +: DW] = blk;
    bus.cmd_iv_i[r*DW +: DW]    = iv;
    bus.lock_i[r]       = lock;
    bus.cmd_iv_upd_i[r] = 1'b1;
    if (nxt) bus.cmd_next_i[r] = 1'b1;
    else     bus.cmd_init_i[r] = 1'b1;
    #1;
    chk("mux_block", bus.core_block, blk);
    chk("mux_iv", bus.core_iv, iv);
    chk("mux_iv_upd", DW'(bus.core_iv_updated), DW'(1'b1));
    tick();
    bus.cmd_init_i   = '0;
    bus.cmd_next_i   = '0;
    bus.cmd_iv_upd_i = '0;
    chk("core_next", DW'(bus.core_next), DW'(nxt));
    chk("core_init", DW'(bus.core_init), DW'(!nxt));
    chk("cmd_err_legal", DW'(bus.cmd_err_o), DW'(1'b0));
    if (!nxt) begin
      // Ready still high before the core goes busy must not complete an init.
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("no_rsp_pre_busy", DW'(bus.rsp_valid_o), '0);
      end
      bus.core_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tick();
        chk("no_rsp_busy", DW'(bus.rsp_valid_o), '0);
      end
      bus.core_ready = 1'b1;
    end else begin
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("no_rsp_wait", DW'(bus.rsp_valid_o), '0);
      end
      bus.core_valid  = 1'b1;
      bus.core_result = res;
    end
    tick();
    bus.core_valid = 1'b0;
    if (nxt) data_m = res;
    if (!lock) ptr_m = (r + 1) % N;
    chk("rsp_valid", DW'(bus.rsp_valid_o), DW'(onehot(r)));
    chk("rsp_err", DW'(bus.rsp_err_o), DW'(1'b0));
    chk("rsp_data", bus.rsp_data_o, data_m);
    chk("gnt_after_rsp", DW'(bus.gnt_o), DW'(lock ? onehot(r) : N'(0)));
  endtask

  // Owner drops request and lock without a command: grant released.
  task automatic release_grant(input int r);
    bus.req_i[r]  = 1'b0;
    bus.lock_i[r] = 1'b0;
    tick();
    ptr_m = (r + 1) % N;
    chk("release_gnt", DW'(bus.gnt_o), '0);
    chk("release_busy", DW'(bus.busy_o), DW'(1'b0));
  endtask

  int           w;
  logic [N-1:0] m;
  bit           nxt;
  bit           lk;

  initial begin
    rst              = 1'b1;
    zeroize          = 1'b0;
    bus.req_i        = '0;
    bus.lock_i       = '0;
    bus.cmd_init_i   = '0;
    bus.cmd_next_i   = '0;
    bus.cmd_block_i  = '0;
    bus.cmd_iv_i     = '0;
    bus.cmd_iv_upd_i = '0;
    bus.core_ready   = 1'b1;
    bus.core_valid   = 1'b0;
    bus.core_result  = '0;

    // Reset values.
    tick();
    tick();
    chk("rst_gnt", DW'(bus.gnt_o), '0);
    chk("rst_rsp_valid", DW'(bus.rsp_valid_o), '0);
    chk("rst_rsp_err", DW'(bus.rsp_err_o), '0);
    chk("rst_rsp_data", bus.rsp_data_o, '0);
    chk("rst_cmd_err", DW'(bus.cmd_err_o), '0);
    chk("rst_core_init", DW'(bus.core_init), '0);
    chk("rst_core_next", DW'(bus.core_next), '0);
    chk("rst_busy", DW'(bus.busy_o), '0);
    chk("rst_core_block", bus.core_block, '0);
    rst = 1'b0;

    // No grant while the core is not ready.
    bus.core_ready = 1'b0;
    bus.req_i      = 2'b01;
    tick();
    chk("no_gnt_not_ready", DW'(bus.gnt_o), '0);
    chk("idle_busy", DW'(bus.busy_o), '0);
    bus.core_ready = 1'b1;

    // Basic next with 0xA5.. result, then re-grant after one idle cycle.
    request(2'b01, w);
    run_cmd(w, 1'b1, 2, 1'b0, {16{8'hA5}});
    request(2'b01, w);
    release_grant(w);

    // Round robin with both requesting, no lock.
    for (int i = 0; i < 4; i++) begin
      request(2'b11, w);
      run_cmd(w, 1'b1, i, 1'b0, rnd128());
    end

    // Requester 1 locked across three commands while 0 requests.
    request(2'b10, w);
    bus.req_i = 2'b11;
    for (int i = 0; i < 3; i++) run_cmd(1, 1'b1, 1, 1'b1, rnd128());
    release_grant(1);
    request(2'b01, w);
    release_grant(w);

    // Illegal commands.
    request(2'b10, w);
    bus.cmd_next_i[0] = 1'b1;
    tick();
    bus.cmd_next_i = '0;
    chk("err_non_owner", DW'(bus.cmd_err_o), DW'(1'b1));
    chk("err_non_owner_no_next", DW'(bus.core_next), DW'(1'b0));
    chk("err_non_owner_gnt", DW'(bus.gnt_o), DW'(2'b10));
    tick();
    chk("err_single_pulse", DW'(bus.cmd_err_o), DW'(1'b0));
    bus.cmd_init_i[1] = 1'b1;
    bus.cmd_next_i[1] = 1'b1;
    tick();
    bus.cmd_init_i = '0;
    bus.cmd_next_i = '0;
    chk("err_both", DW'(bus.cmd_err_o), DW'(1'b1));
    chk("err_both_no_init", DW'(bus.core_init), DW'(1'b0));
    chk("err_both_no_next", DW'(bus.core_next), DW'(1'b0));
    chk("err_both_gnt", DW'(bus.gnt_o), DW'(2'b10));
    run_cmd(1, 1'b0, 1, 1'b0, '0);
    bus.req_i         = '0;
    bus.cmd_next_i[0] = 1'b1;
    tick();
    bus.cmd_next_i = '0;
    chk("err_idle", DW'(bus.cmd_err_o), DW'(1'b1));
    chk("err_idle_no_next", DW'(bus.core_next), DW'(1'b0));

    // Zeroize in the completion cycle wins.
    request(2'b10, w);
    bus.cmd_next_i[1] = 1'b1;
    tick();
    bus.cmd_next_i = '0;
    chk("zer_core_next", DW'(bus.core_next), DW'(1'b1));
    bus.core_valid  = 1'b1;
    bus.core_result = rnd128();
    zeroize         = 1'b1;
    bus.req_i       = 2'b11;
    tick();
    bus.core_valid = 1'b0;
    zeroize        = 1'b0;
    ptr_m  = 0;
    data_m = '0;
    chk("zer_no_rsp", DW'(bus.rsp_valid_o), '0);
    chk("zer_gnt", DW'(bus.gnt_o), '0);
    chk("zer_busy", DW'(bus.busy_o), '0);
    chk("zer_data", bus.rsp_data_o, data_m);
    request(2'b11, w);
    chk("zer_next_gnt_req0", DW'(bus.gnt_o), DW'(2'b01));
    release_grant(w);

`ifdef DOE_ARB_WDT_EN
    // Watchdog: answer with error TMO+1 cycles after entering WAIT, lock ignored.
    request(2'b01, w);
    bus.lock_i[0]     = 1'b1;
    bus.cmd_next_i[0] = 1'b1;
    tick();
    bus.cmd_next_i = '0;
    chk("wdt_core_next", DW'(bus.core_next), DW'(1'b1));
    for (int i = 0; i < TMO; i++) begin
      tick();
      chk("wdt_no_rsp", DW'(bus.rsp_valid_o), '0);
    end
    bus.req_i  = '0;
    bus.lock_i = '0;
    tick();
    ptr_m = 1;
    chk("wdt_rsp_valid", DW'(bus.rsp_valid_o), DW'(2'b01));
    chk("wdt_rsp_err", DW'(bus.rsp_err_o), DW'(1'b1));
    chk("wdt_gnt", DW'(bus.gnt_o), '0);
    chk("wdt_data", bus.rsp_data_o, data_m);
    tick();
    chk("wdt_err_pulse", DW'(bus.rsp_err_o), DW'(1'b0));
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 30; it++) begin
      m   = N'($urandom_range(1, (1 << N) - 1));
      nxt = 1'($urandom_range(0, 1));
      lk  = 1'($urandom_range(0, 1));
      request(m, w);
      run_cmd(w, nxt, int'($urandom_range(0, 3)), lk, rnd128());
      if (lk) run_cmd(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, rnd128());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/doe_core_arb.md
# doe_core_arb

Round-robin arbiter and sequencer that shares one `doe_core_cbc` instance between `NUM_REQ` requesters, e.g. the `doe_fsm` deobfuscation flows plus a secondary hardware client. It issues the core's init/next strobes and muxes block and IV from the granted requester. It also tracks completion and returns the result to the granted requester only. It sits between the requesters and the core inside the DOE top, and all core-side handshakes are single-pulse.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles; only used when the watchdog is compiled in.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `zeroize` in 1: synchronous abort and clear, same priority as `rst`.
- `req_i` in NUM_REQ: requester wants the core.
- `lock_i` in NUM_REQ: owner keeps the grant after the current command completes.
- `cmd_init_i`, `cmd_next_i` in NUM_REQ: one-cycle command strobes.
- `cmd_block_i` in NUM_REQ*128: block; requester r uses slice [r*128 +: 128].
- `cmd_iv_i` in NUM_REQ*128: IV, same slicing as `cmd_block_i`.
- `cmd_iv_upd_i` in NUM_REQ: IV-updated pulse.
- `gnt_o` out NUM_REQ: one-hot grant.
- `rsp_valid_o` out NUM_REQ: one-cycle completion pulse.
- `rsp_err_o` out 1: qualifies `rsp_valid_o`.
- `rsp_data_o` out 128: registered `core_result`.
- `cmd_err_o` out 1: one-cycle pulse flagging an illegal command.
- `busy_o` out 1: high whenever the state is not IDLE.
- `core_init`, `core_next` out 1: one-cycle core strobes.
- `core_block`, `core_iv` out 128: muxed from the granted requester, zero when there is no grant.
- `core_iv_updated` out 1: muxed `cmd_iv_upd_i`.
- `core_ready`, `core_valid` in 1: core status.
- `core_result` in 128: core result.

## Operation
- States are IDLE, GRANTED, WAIT.
- Reset and zeroize values:
  - `gnt_o`, `rsp_valid_o`, `rsp_err_o`, `cmd_err_o`, `core_init`, `core_next`, `busy_o` are 0.
  - `rsp_data_o` is 0.
  - Round-robin pointer is 0; state is IDLE.
- IDLE: when `core_ready`=1 and any `req_i` is set, grant the first set requester at or after the pointer, wrapping modulo NUM_REQ, then go to GRANTED. When `core_ready`=0, nothing is granted.
- GRANTED, owner strobes exactly one of init/next:
  - Register `core_init` or `core_next` high for one cycle and go to WAIT.
  - Record the command type.
  - Clear the `seen_busy` flag.
- GRANTED, owner drops `req_i` with `lock_i`=0 and no command: go to IDLE, and the pointer moves to owner+1.
- WAIT, init command: sets `seen_busy` when `core_ready`=0, and completes on the first `core_ready`=1 after `seen_busy`.
- WAIT, next command: completes on `core_valid`=1.
- On completion:
  - Pulse the owner's `rsp_valid_o` with `rsp_err_o`=0.
  - For a next command, `rsp_data_o` is `core_result` captured that cycle; for an init command it is unchanged.
  - If owner `lock_i`=1, go to GRANTED with the same owner; otherwise go to IDLE and set the pointer to owner+1.
- `cmd_err_o` pulses, with no core strobe issued, on any of:
  - a strobe from a non-owner;
  - a strobe outside GRANTED;
  - `cmd_init_i` and `cmd_next_i` asserted together.
- Zeroize:
  - Applies in any state: go to IDLE, clear the grant, reset the pointer to 0.
  - No `rsp_valid_o` is issued for an aborted command.
  - `zeroize` and a completion in the same cycle: zeroize wins.
- Block and IV mux: combinational from the `gnt_o` owner. Requesters hold `cmd_block_i` and `cmd_iv_i` stable from their strobe until `rsp_valid_o`.

## Timing
- Request to grant: `req_i` sampled at cycle N in IDLE with `core_ready`=1 gives `gnt_o` at N+1.
- Command to core: strobe at M in GRANTED gives the core strobe at M+1, with state WAIT from M+1.
- Core to response: `core_valid` (or qualifying `core_ready`) at K gives `rsp_valid_o` and `rsp_data_o` at K+1.
- Back-to-back commands:
  - Locked owner: can issue a new strobe at K+1, so the next core strobe is at K+2.
  - Other requester: grant earliest at K+2.
- Single requester continuously requesting: re-granted after each release, with one idle cycle between grants.

## Configuration
- `DOE_ARB_WDT_EN` defined:
  - A 32-bit counter runs in WAIT and clears on entering WAIT.
  - When it reaches `TIMEOUT_CYCLES`: pulse the owner's `rsp_valid_o` with `rsp_err_o`=1, go to IDLE, set the pointer to owner+1, and ignore the lock.
- Undefined:
  - No counter is present; WAIT waits indefinitely.
  - `rsp_err_o` is tied to 0.

## Test plan
- Basic next: NUM_REQ=2, requester 0 requests, `core_ready`=1 → `gnt_o`=01 next cycle. Strobe next → `core_next` pulse. `core_valid` with result 0xA5..A5 → `rsp_valid_o`=01 one cycle later, `rsp_data_o`=0xA5..A5.
- Round robin: both requesters hold `req_i`, `lock_i`=0, two next commands each → grant order 0,1,0,1.
- Lock: requester 1 holds `lock_i`=1 across 3 next commands while requester 0 requests → requester 1 keeps the grant for all 3, then requester 0 is granted 2 cycles after the third `rsp_valid_o`.
- Illegal commands: requester 0 strobes next while requester 1 is granted → `cmd_err_o` pulses once, no `core_next`. Init and next together → `cmd_err_o` pulses.
- Zeroize: zeroize asserted in the same cycle as `core_valid` → no `rsp_valid_o`, state IDLE, `gnt_o`=0, next grant goes to requester 0.
- Watchdog: with `DOE_ARB_WDT_EN`, `TIMEOUT_CYCLES`=16, and no `core_valid` → `rsp_valid_o` with `rsp_err_o`=1 exactly 16 cycles after entering WAIT, plus 1.
